// File: rtl/spi_master_seq.sv
// Byte-level SPI mode-3 master (CPOL=1, CPHA=1, MSB first) with start/busy/done
// handshake and optional chip-select hold across consecutive bytes.
module spi_master_seq #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 125,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              hold_cs,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sclk,
    output logic              cs_n,
    output logic              mosi,
    input  logic              miso
);
    localparam int BC_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [BC_W-1:0]  BIT_LAST = BC_W'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  div;
    logic [BC_W-1:0]   bit_cnt;
    logic [DATA_W-1:0] sr;
    logic              hold_lat;
    logic              cs_held;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            div      <= '0;
            bit_cnt  <= '0;
            sr       <= '0;
            hold_lat <= 1'b0;
            cs_held  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rx_data  <= '0;
            sclk     <= 1'b1;
            cs_n     <= 1'b1;
            mosi     <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sr       <= tx_data;
                        hold_lat <= hold_cs;
                        busy     <= 1'b1;
                        div      <= '0;
                        bit_cnt  <= '0;
                        cs_n     <= 1'b0;
                        mosi     <= tx_data[DATA_W-1];
                        // cs_n is already low from the previous byte: the
                        // accept edge doubles as the first falling sclk edge.
                        if (cs_held) begin
                            sclk  <= 1'b0;
                            state <= SHIFT;
                        end else begin
                            state <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    if (div == DIV_LAST) begin
                        div   <= '0;
                        sclk  <= 1'b0;
                        state <= SHIFT;
                    end else begin
                        div <= div + CNT_W'(1);
                    end
                end
                SHIFT: begin
                    if (div == DIV_LAST) begin
                        div  <= '0;
                        sclk <= ~sclk;
                        if (!sclk) begin
                            // Rising edge: capture miso; the shifted register
                            // presents the next tx bit at its MSB.
                            sr      <= {sr[DATA_W-2:0], miso};
                            bit_cnt <= bit_cnt + BC_W'(1);
                            if (bit_cnt == BIT_LAST) state <= HOLD;
                        end else begin
                            mosi <= sr[DATA_W-1];
                        end
                    end else begin
                        div <= div + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (div == DIV_LAST) begin
                        div     <= '0;
                        cs_n    <= ~hold_lat;
                        cs_held <= hold_lat;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        rx_data <= sr;
                        if (!hold_lat) mosi <= 1'b1;
                        state   <= DONE;
                    end else begin
                        div <= div + CNT_W'(1);
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_seq.sv
// Scoreboard bench for spi_master_seq: expected rx bytes queued at start,
// checked when done pulses; timing, edge counts and reset behaviour checked inline.
module tb_spi_master_seq;
    localparam int DW = 8;
    localparam int CD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          hold_cs = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          busy, done, sclk, cs_n, mosi, miso;
    logic [DW-1:0] rx_data;

    logic          loop_mode = 1'b1;
    logic          slave_bit = 1'b1;
    logic [DW-1:0] slave_byte = '0;
    int            slave_idx = -1;

    int checks = 0, errors = 0;
    int done_cnt = 0, rise_cnt = 0, fall_cnt = 0;
    logic [DW-1:0] mosi_bits = '0;
    logic [DW-1:0] rx_q[$];

    assign miso = loop_mode ? mosi : slave_bit;

    spi_master_seq #(.DATA_W(DW), .CLK_DIV(CD), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data),
        .hold_cs(hold_cs), .busy(busy), .done(done), .rx_data(rx_data),
        .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso)
    );

    always #5 clk = ~clk;

    always @(posedge sclk) begin
        rise_cnt++;
        mosi_bits = {mosi_bits[DW-2:0], mosi};
    end

    // Slave model: presents its next bit on every falling edge while selected.
    always @(negedge sclk) begin
        fall_cnt++;
        if (!cs_n && slave_idx >= 0) begin
            slave_bit = slave_byte[slave_idx];
            slave_idx--;
        end
    end

    always @(posedge clk) begin
        logic [DW-1:0] exp_rx;
        #1;
        if (done) begin
            done_cnt++;
            checks++;
            if (rx_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done rx_data=%h (no transfer expected)", rx_data);
            end else begin
                exp_rx = rx_q.pop_front();
                if (rx_data !== exp_rx) begin
                    errors++;
                    $display("FAIL rx_data got=%h exp=%h", rx_data, exp_rx);
                end
            end
        end
    end

    task automatic do_start(input logic [DW-1:0] d, input logic h, input logic [DW-1:0] exp_rx);
        @(negedge clk);
        tx_data = d;
        hold_cs = h;
        start   = 1'b1;
        rx_q.push_back(exp_rx);
        @(posedge clk);
        #1;
        start   = 1'b0;
        tx_data = ~d;      // later changes must not affect the transfer
        hold_cs = ~h;
    endtask

    // Returns n = cycle index relative to the accept cycle T at which done is seen.
    task automatic wait_done(output int n, output int cs_hi);
        n = 1;
        cs_hi = 0;
        if (!done) begin
            while (n < 2000) begin
                if (cs_n) cs_hi++;
                @(posedge clk);
                #1;
                n++;
                if (done) break;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout got=no_done exp=done within 2000 cycles");
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({sclk, cs_n, mosi, busy, done, rx_data} !== {5'b11100, 8'h00}) begin
            errors++;
            $display("FAIL reset_state got=%b%b%b%b%b/%h exp=11100/00", sclk, cs_n, mosi, busy, done, rx_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_loopback();
        int n, hi;
        loop_mode = 1'b1;
        do_start(8'h13, 1'b0, 8'h13);
        checks++;
        if (busy !== 1'b1 || cs_n !== 1'b0) begin
            errors++;
            $display("FAIL accept_t1 got busy=%b cs_n=%b exp busy=1 cs_n=0", busy, cs_n);
        end
        wait_done(n, hi);
        checks++;
        if (n != 69) begin
            errors++;
            $display("FAIL loop_latency got=%0d exp=69", n);
        end
        checks++;
        if (cs_n !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL loop_done_pins got cs_n=%b busy=%b exp cs_n=1 busy=0", cs_n, busy);
        end
        checks++;
        if (mosi_bits !== 8'h13) begin
            errors++;
            $display("FAIL loop_mosi_bits got=%h exp=13", mosi_bits);
        end
        checks++;
        if (hi != 0) begin
            errors++;
            $display("FAIL loop_cs_low got=%0d high cycles exp=0", hi);
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_slave();
        int n, hi;
        loop_mode  = 1'b0;
        slave_byte = 8'hA5;
        slave_idx  = DW - 1;
        rise_cnt   = 0;
        fall_cnt   = 0;
        do_start(8'h3C, 1'b0, 8'hA5);
        wait_done(n, hi);
        checks++;
        if (rx_data !== 8'hA5) begin
            errors++;
            $display("FAIL slave_rx got=%h exp=a5", rx_data);
        end
        checks++;
        if (rise_cnt != DW || fall_cnt != DW) begin
            errors++;
            $display("FAIL slave_edges got rise=%0d fall=%0d exp=8/8", rise_cnt, fall_cnt);
        end
        checks++;
        if (mosi_bits !== 8'h3C) begin
            errors++;
            $display("FAIL slave_mosi_bits got=%h exp=3c", mosi_bits);
        end
        loop_mode = 1'b1;
        slave_idx = -1;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_burst();
        int n, hi;
        do_start(8'h01, 1'b1, 8'h01);
        wait_done(n, hi);
        checks++;
        if (n != 69 || cs_n !== 1'b0 || hi != 0) begin
            errors++;
            $display("FAIL burst_first got n=%0d cs_n=%b hi=%0d exp n=69 cs_n=0 hi=0", n, cs_n, hi);
        end
        @(posedge clk);
        #1;
        checks++;
        if (cs_n !== 1'b0) begin
            errors++;
            $display("FAIL burst_gap_cs got cs_n=%b exp=0", cs_n);
        end
        do_start(8'h02, 1'b0, 8'h02);
        wait_done(n, hi);
        checks++;
        if (n != 65) begin
            errors++;
            $display("FAIL burst_second_latency got=%0d exp=65", n);
        end
        checks++;
        if (hi != 0 || cs_n !== 1'b1 || mosi !== 1'b1) begin
            errors++;
            $display("FAIL burst_release got hi=%0d cs_n=%b mosi=%b exp hi=0 cs_n=1 mosi=1", hi, cs_n, mosi);
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_busy_ignore();
        int n, hi, d0;
        d0 = done_cnt;
        do_start(8'h13, 1'b0, 8'h13);
        repeat (20) @(posedge clk);
        @(negedge clk);
        tx_data = 8'hFF;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_mid got=%b exp=1", busy);
        end
        wait_done(n, hi);
        checks++;
        if (rx_data !== 8'h13 || mosi_bits !== 8'h13) begin
            errors++;
            $display("FAIL busy_ignore_data got rx=%h mosi_bits=%h exp=13/13", rx_data, mosi_bits);
        end
        repeat (100) @(posedge clk);
        #2;
        checks++;
        if (done_cnt != d0 + 1) begin
            errors++;
            $display("FAIL busy_ignore_dones got=%0d exp=1", done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid();
        int d0, k;
        d0 = done_cnt;
        rise_cnt = 0;
        do_start(8'h5A, 1'b0, 8'h5A);
        k = 0;
        while (rise_cnt < 3 && k < 500) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (rise_cnt < 3) begin
            errors++;
            $display("FAIL reset_mid_wait got rise=%0d exp>=3", rise_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({sclk, cs_n, mosi, busy, done, rx_data} !== {5'b11100, 8'h00}) begin
            errors++;
            $display("FAIL reset_mid_state got=%b%b%b%b%b/%h exp=11100/00", sclk, cs_n, mosi, busy, done, rx_data);
        end
        rx_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #2;
        checks++;
        if (done_cnt != d0) begin
            errors++;
            $display("FAIL reset_mid_done got=%0d dones exp=0", done_cnt - d0);
        end
    endtask

    task automatic test_back_to_back();
        int n, hi;
        do_start(8'hC3, 1'b0, 8'hC3);
        wait_done(n, hi);
        @(negedge clk);
        tx_data = 8'hAA;
        start   = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done_cycle got busy=%b exp=0", busy);
        end
        tx_data = 8'h66;
        rx_q.push_back(8'h66);
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || cs_n !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_accept got busy=%b cs_n=%b exp=1/0", busy, cs_n);
        end
        wait_done(n, hi);
        checks++;
        if (n != 69 || mosi_bits !== 8'h66) begin
            errors++;
            $display("FAIL b2b_second got n=%0d bits=%h exp 69/66", n, mosi_bits);
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_slave();
        test_burst();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        #2;
        checks++;
        if (rx_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", rx_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_master_seq.md
Name: spi_master_seq

Overview:
- Byte-level SPI master sequencer that drives the sclk/cs_n/mosi pins of the team's SPI slave (`top`) and captures miso.
- Replaces hand-timed testbench stimulus in system simulation, and serves as the on-chip master in loopback builds.
- Mode 3 only: CPOL=1, CPHA=1, MSB first.
- Host side uses a start/busy/done handshake, with optional chip-select hold for multi-byte bursts.

Parameters:
- DATA_W, 8: bits per transfer.
- CLK_DIV, 125: sclk half-period in clk cycles. Must be ≥ 2.
- CNT_W, 8: width of the divider counter. Must satisfy 2^CNT_W > CLK_DIV.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request. Accepted only when busy=0.
- tx_data  in  DATA_W  byte to send. Sampled in the start-accept cycle.
- hold_cs  in  1  sampled with start. If 1, cs_n stays low after this transfer.
- busy  out  1  high from the cycle after start accept until done.
- done  out  1  one-cycle pulse when the transfer completes.
- rx_data  out  DATA_W  byte received on miso. Valid from done, held until the next done.
- sclk  out  1  SPI clock, idle high.
- cs_n  out  1  chip select, active low.
- mosi  out  1  serial data to slave.
- miso  in  1  serial data from slave.

Behaviour:
- Reset (asynchronous, immediate, also mid-transfer):
  - state=IDLE; sclk=1, cs_n=1, mosi=1, busy=0, done=0, rx_data=0; counters=0; cs_held=0.
  - Reset mid-transfer aborts without a done pulse.
- State machine: IDLE, SETUP, SHIFT, HOLD, DONE.
- IDLE:
  - start=1 latches tx_data into the shift register and latches hold_cs.
  - If cs_held=0: next state SETUP. If cs_held=1: next state SHIFT (SETUP skipped).
  - start while busy=1 is ignored; no queueing.
- SETUP:
  - cs_n=0, mosi=tx[DATA_W-1].
  - Divider counts 0..CLK_DIV-1, then enters SHIFT.
- SHIFT:
  - Divider counts 0..CLK_DIV-1. On terminal count, sclk toggles and the divider clears.
  - Falling edge (1→0): on the first falling edge mosi keeps the MSB; on later falling edges mosi shifts to the next lower bit.
  - Rising edge (0→1): miso is sampled into the shift-register LSB in the same cycle sclk goes high; bit_cnt increments.
  - After the DATA_W-th rising edge: enter HOLD with sclk=1.
- HOLD:
  - Waits CLK_DIV cycles with sclk=1 and cs_n=0.
  - At the end, cs_n=1 if latched hold_cs=0, otherwise cs_n stays 0.
  - cs_held <= latched hold_cs.
- DONE (1 cycle):
  - done=1, rx_data <= shift register, busy=0 in the same cycle.
  - mosi=1 if cs_n returned high, else mosi holds its last bit.
  - Next state IDLE.
  - start asserted in the DONE cycle is ignored; it is accepted only in IDLE.
- Latency (start accepted at cycle T, cs_held=0):
  - cs_n falls and busy rises at T+1.
  - First sclk falling edge at T+1+CLK_DIV.
  - Last rising edge at T+1+2·DATA_W·CLK_DIV.
  - done and cs_n rise at T+1+(2·DATA_W+1)·CLK_DIV.
  - With cs_held=1, every time after T is earlier by CLK_DIV.
- Edge counts: exactly DATA_W falling and DATA_W rising sclk edges per transfer. sclk never toggles while cs_n=1.
- Burst end: a transfer started with hold_cs=0 while cs_held=1 skips SETUP and releases cs_n at its end.
- Mid-transfer input changes: tx_data and hold_cs changes after acceptance have no effect.
- All outputs are registered; there is no combinational path from miso to any output.

Test Plan (CLK_DIV=4, DATA_W=8):
- Reset 3 cycles, then start with tx_data=8'h13, hold_cs=0, miso tied to mosi:
  - mosi bits 0,0,0,1,0,0,1,1 at successive rising edges; rx_data=8'h13.
  - done exactly 69 cycles after start accept; cs_n high in the done cycle.
- Slave model drives miso=8'hA5 MSB-first, changing on falling edges, while tx_data=8'h3C:
  - rx_data=8'hA5 at done; exactly 8 rising and 8 falling sclk edges counted.
- Burst: 8'h01 with hold_cs=1, then 8'h02 with hold_cs=0, started on the cycle after done:
  - cs_n stays low across both bytes.
  - The second done comes 65 cycles after its start accept.
  - cs_n rises only after the second byte.
- Start pulsed while busy=1 with tx_data=8'hFF: ignored; the in-flight byte 8'h13 completes unchanged and only one done is seen.
- rst_n pulsed low after the 3rd rising edge: outputs return to sclk=1, cs_n=1, busy=0, rx_data=0 without waiting for clk; no done pulse occurs.
- Back-to-back: start asserted in the DONE cycle is ignored; start in the following IDLE cycle is accepted.
